axis_wrr_sched: RTL and testbench

AXIS_WRR_SCHED -- requirements
Module: axis_wrr_sched

---
 rtl/axis_wrr_sched_pkg.sv | 12 +
 rtl/axis_wrr_pick.sv | 31 +++
 rtl/axis_wrr_sched.sv | 129 ++++++++++++
 tb/tb_axis_wrr_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_wrr_sched_pkg.sv
// rtl/axis_wrr_sched_pkg.sv - shared state encoding and constants for the weighted round-robin scheduler
package axis_wrr_sched_pkg;

  // Two-state arbiter: ARB searches for the next port, GRANT holds it until end of packet
  typedef logic [0:0] wrr_state_t;
  localparam wrr_state_t ST_ARB   = 1'b0;
  localparam wrr_state_t ST_GRANT = 1'b1;

  // Width of the completed-turn statistics counter
  localparam int STAT_WIDTH = 32;

endpackage

// File: rtl/axis_wrr_pick.sv
// rtl/axis_wrr_pick.sv - rotating-priority search starting just above the pointer
module axis_wrr_pick #(
  parameter  int S_COUNT    = 4,
  localparam int CL_S_COUNT = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]    i_eligible,
  input  logic [CL_S_COUNT-1:0] i_ptr,
  output logic                  o_found,
  output logic [S_COUNT-1:0]    o_onehot,
  output logic [CL_S_COUNT-1:0] o_index
);

  logic [CL_S_COUNT-1:0] w_pos;

  // Walk ptr+1, ptr+2, ... ptr+S_COUNT (mod S_COUNT); the pointer itself is checked last
  always_comb begin
    o_found  = 1'b0;
    o_onehot = '0;
    o_index  = '0;
    w_pos    = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      w_pos = CL_S_COUNT'((int'(i_ptr) + k) % S_COUNT);
      if (!o_found && i_eligible[w_pos]) begin
        o_found         = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_index         = w_pos;
      end
    end
  end

endmodule

// File: rtl/axis_wrr_sched.sv
// rtl/axis_wrr_sched.sv - weighted round-robin packet scheduler; AXIS_WRR_SCHED_STATS_EN enables the turn counter
module axis_wrr_sched
  import axis_wrr_sched_pkg::*;
#(
  parameter  int S_COUNT      = 4,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int CL_S_COUNT   = $clog2(S_COUNT)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [S_COUNT-1:0]              request,
  input  logic [S_COUNT-1:0]              acknowledge,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] cfg_weight,
  output logic [S_COUNT-1:0]              grant,
  output logic                            grant_valid,
  output logic [CL_S_COUNT-1:0]           grant_encoded,
  output logic [STAT_WIDTH-1:0]           stat_turns
);

  wrr_state_t              r_state;
  logic [CL_S_COUNT-1:0]   r_ptr;
  logic [WEIGHT_WIDTH-1:0] r_credit;
  logic [S_COUNT-1:0]      r_grant;
  logic                    r_grant_valid;
  logic [CL_S_COUNT-1:0]   r_enc;

  logic [WEIGHT_WIDTH-1:0] w_weight [S_COUNT];
  logic [S_COUNT-1:0]      w_nonzero;
  logic [S_COUNT-1:0]      w_eligible;
  logic [S_COUNT-1:0]      w_ptr_onehot;
  logic                    w_regrant;
  logic                    w_ack;
  logic                    w_found;
  logic [S_COUNT-1:0]      w_pick_onehot;
  logic [CL_S_COUNT-1:0]   w_pick_index;

  // Slice the packed weight bus; a zero weight removes the port from arbitration
  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
    assign w_weight[gi]  = cfg_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign w_nonzero[gi] = |w_weight[gi];
  end

  assign w_eligible   = request & w_nonzero;
  assign w_ptr_onehot = S_COUNT'(1) << r_ptr;

  // The current port keeps its turn while it still has credit, is requesting and is enabled
  assign w_regrant = (r_credit != '0) && request[r_ptr] && w_nonzero[r_ptr];

  // Only the end-of-packet handshake of the granted port counts
  assign w_ack = acknowledge[r_enc];

  axis_wrr_pick #(
    .S_COUNT (S_COUNT)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_found    (w_found),
    .o_onehot   (w_pick_onehot),
    .o_index    (w_pick_index)
  );

  // Arbitration FSM: one-cycle grant decision, hold until acknowledge, then one idle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ARB;
      r_ptr         <= CL_S_COUNT'(S_COUNT - 1);
      r_credit      <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_enc         <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_regrant) begin
            r_state       <= ST_GRANT;
            r_grant       <= w_ptr_onehot;
            r_grant_valid <= 1'b1;
            r_enc         <= r_ptr;
          end else if (w_found) begin
            r_state       <= ST_GRANT;
            r_ptr         <= w_pick_index;
            r_credit      <= w_weight[w_pick_index];
            r_grant       <= w_pick_onehot;
            r_grant_valid <= 1'b1;
            r_enc         <= w_pick_index;
          end else begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_ack) begin
            r_state       <= ST_ARB;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_credit      <= (r_credit != '0) ? r_credit - WEIGHT_WIDTH'(1) : '0;
          end
        end
        default: begin
          r_state       <= ST_ARB;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = r_grant_valid;
  assign grant_encoded = r_enc;

`ifdef AXIS_WRR_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_turns;

  // Count turns: an acknowledge that spends the last credit closes the port's turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_turns <= '0;
    end else if ((r_state == ST_GRANT) && w_ack && (r_credit == WEIGHT_WIDTH'(1))) begin
      r_stat_turns <= r_stat_turns + STAT_WIDTH'(1);
    end
  end

  assign stat_turns = r_stat_turns;
`else
  assign stat_turns = '0;
`endif

endmodule

// File: tb/tb_axis_wrr_sched.sv
// tb/tb_axis_wrr_sched.sv - self-checking bench for axis_wrr_sched
module tb_axis_wrr_sched;

`ifdef AXIS_WRR_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  request = '0;
  logic [3:0]  acknowledge = '0;
  logic [15:0] cfg_weight = '0;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;
  logic [31:0] stat_turns;

  axis_wrr_sched #(
    .S_COUNT      (4),
    .WEIGHT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .request       (request),
    .acknowledge   (acknowledge),
    .cfg_weight    (cfg_weight),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .stat_turns    (stat_turns)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which port holds the turn, how many packets it has left, and whether a packet is in flight
  int          wts [4];
  bit          m_busy;
  int          m_port;
  int          m_credit;
  int          m_enc;
  logic [31:0] m_turns;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [15:0] w;
    logic [3:0]  g;
    logic        v;
    logic [1:0]  enc;
    logic [31:0] turns;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_w();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'(wts[i]);
    return v;
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0; m_port = 3; m_credit = 0; m_enc = 0; m_turns = '0;
  endfunction

  function automatic void model_step(input logic [3:0] req, input logic [3:0] ack);
    int found;
    if (!m_busy) begin
      if (m_credit > 0 && req[m_port] && wts[m_port] != 0) begin
        m_busy = 1'b1;
        m_enc  = m_port;
      end else begin
        found = -1;
        for (int k = 1; k <= 4; k++) begin
          int p;
          p = (m_port + k) % 4;
          if (found < 0 && req[p] && wts[p] != 0) found = p;
        end
        if (found >= 0) begin
          m_port = found; m_credit = wts[found]; m_busy = 1'b1; m_enc = found;
        end
      end
    end else if (ack[m_enc]) begin
      if (m_credit == 1) m_turns = m_turns + 1;
      if (m_credit > 0) m_credit = m_credit - 1;
      m_busy = 1'b0;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_grant"}, grant, m_busy ? (32'd1 << m_enc) : 32'd0);
    check({tag, "_valid"}, grant_valid, m_busy);
    check({tag, "_enc"}, grant_encoded, m_enc);
    check({tag, "_turns"}, stat_turns, STATS ? m_turns : 32'd0);
  endtask

  // One clock of stimulus, model update on the edge, outputs compared on the falling edge
  task automatic cycle(input string tag, input logic [3:0] req, input logic [3:0] ack);
    request = req; acknowledge = ack; cfg_weight = pack_w();
    @(posedge clk);
    model_step(req, ack);
    @(negedge clk);
    check_model(tag);
  endtask

  // Asserts reset between edges; the grant must vanish without waiting for a clock
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_grant", grant, 4'b0000);
    check("rst_async_valid", grant_valid, 1'b0);
    request = '0; acknowledge = '0;
    model_reset();
    @(negedge clk);
    check("rst_enc", grant_encoded, 2'd0);
    check("rst_turns", stat_turns, 32'd0);
    rst_n = 1'b1;
  endtask

  function automatic void add(input bit rst, input logic [3:0] req, input logic [3:0] ack, input logic [15:0] w,
                              input logic [3:0] g, input logic v, input logic [1:0] enc, input logic [31:0] turns);
    vec_t t;
    t.rst = rst; t.req = req; t.ack = ack; t.w = w; t.g = g; t.v = v; t.enc = enc; t.turns = turns;
    vecs.push_back(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] a;

    // Equal weights, everyone requesting: strict rotation with an idle cycle after each packet
    add(1, 4'b1111, 4'b0000, 16'h1111, 4'b0001, 1, 0, 0);
    add(0, 4'b1111, 4'b0001, 16'h1111, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 4'b0000, 16'h1111, 4'b0010, 1, 1, 1);
    add(0, 4'b1111, 4'b0010, 16'h1111, 4'b0000, 0, 1, 2);
    add(0, 4'b1111, 4'b0000, 16'h1111, 4'b0100, 1, 2, 2);
    add(0, 4'b1111, 4'b0100, 16'h1111, 4'b0000, 0, 2, 3);
    add(0, 4'b1111, 4'b0000, 16'h1111, 4'b1000, 1, 3, 3);
    add(0, 4'b1111, 4'b1000, 16'h1111, 4'b0000, 0, 3, 4);
    add(0, 4'b1111, 4'b0000, 16'h1111, 4'b0001, 1, 0, 4);
    // Weights {3,1,0,0}: three packets from port 0, then one from port 1
    add(1, 4'b0011, 4'b0000, 16'h0013, 4'b0001, 1, 0, 0);
    add(0, 4'b0011, 4'b0001, 16'h0013, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 4'b0000, 16'h0013, 4'b0001, 1, 0, 0);
    add(0, 4'b0011, 4'b0001, 16'h0013, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 4'b0000, 16'h0013, 4'b0001, 1, 0, 0);
    add(0, 4'b0011, 4'b0001, 16'h0013, 4'b0000, 0, 0, 1);
    add(0, 4'b0011, 4'b0000, 16'h0013, 4'b0010, 1, 1, 1);
    add(0, 4'b0011, 4'b0010, 16'h0013, 4'b0000, 0, 1, 2);
    add(0, 4'b0011, 4'b0000, 16'h0013, 4'b0001, 1, 0, 2);
    add(0, 4'b0011, 4'b0001, 16'h0013, 4'b0000, 0, 0, 2);
    add(0, 4'b0011, 4'b0000, 16'h0013, 4'b0001, 1, 0, 2);
    add(0, 4'b0011, 4'b0001, 16'h0013, 4'b0000, 0, 0, 2);
    add(0, 4'b0011, 4'b0000, 16'h0013, 4'b0001, 1, 0, 2);
    add(0, 4'b0011, 4'b0001, 16'h0013, 4'b0000, 0, 0, 3);
    add(0, 4'b0011, 4'b0000, 16'h0013, 4'b0010, 1, 1, 3);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      request = vecs[i].req; acknowledge = vecs[i].ack; cfg_weight = vecs[i].w;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), grant, vecs[i].g);
      check($sformatf("vec%0d_valid", i), grant_valid, vecs[i].v);
      check($sformatf("vec%0d_enc", i), grant_encoded, vecs[i].enc);
      check($sformatf("vec%0d_turns", i), stat_turns, STATS ? vecs[i].turns : 32'd0);
    end

    // Idle after reset stays idle; a late request is granted one edge later
    wts = '{1, 1, 1, 1};
    apply_reset();
    repeat (20) cycle("idle", 4'b0000, 4'b0000);
    cycle("late_req", 4'b0001, 4'b0000);
    check("late_req_const", grant, 4'b0001);

    // A requesting port with zero weight is never granted
    wts = '{1, 1, 0, 1};
    apply_reset();
    repeat (8) cycle("zero_w", 4'b0100, 4'b0000);
    check("zero_w_const", grant_valid, 1'b0);

    // Foreign acknowledge and a request drop do not end the grant
    wts = '{2, 2, 2, 2};
    apply_reset();
    cycle("hold_start", 4'b0010, 4'b0000);
    cycle("hold_other_ack", 4'b0010, 4'b0100);
    check("hold_other_ack_const", grant, 4'b0010);
    cycle("hold_req_drop", 4'b0000, 4'b0000);
    check("hold_req_drop_const", grant, 4'b0010);
    cycle("hold_end", 4'b0000, 4'b0010);
    check("hold_end_const", grant_valid, 1'b0);

    // Reset in the middle of a turn discards the remaining credit
    wts = '{1, 1, 1, 3};
    apply_reset();
    cycle("mid_g0", 4'b1000, 4'b0000);
    cycle("mid_a0", 4'b1000, 4'b1000);
    cycle("mid_g1", 4'b1000, 4'b0000);
    check("mid_g1_const", grant, 4'b1000);
    apply_reset();
    cycle("post_g0", 4'b1000, 4'b0000);
    check("post_g0_const", grant, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      cycle("post_a", 4'b1100, 4'b1000);
      cycle("post_g", 4'b1100, 4'b0000);
    end
    check("post_reload_const", grant, 4'b0100);

    // Random traffic, weights and occasional resets against the model
    wts = '{1, 2, 3, 1};
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0)
        for (int i = 0; i < 4; i++) wts[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 199) == 0) apply_reset();
      r = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      if (m_busy) begin
        if ($urandom_range(0, 2) == 0) a[m_enc] = 1'b1;
        else a[m_enc] = 1'b0;
      end
      cycle("rand", r, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
